// File: rtl/degenerate_mux_pkg.sv
// Shared select encodings and error-counter sizing for the degenerate 3:1 mux.
// No logic; constants only.
// No flow control.
package degenerate_mux_pkg;

    localparam logic [1:0] SEL_IN0 = 2'b00;
    localparam logic [1:0] SEL_IN1 = 2'b01;
    localparam logic [1:0] SEL_IN2 = 2'b10;
    localparam logic [1:0] SEL_INV = 2'b11;

    localparam int ERR_CNT_W = 8;
    localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'hFF;

endpackage

// File: rtl/degenerate_mux_3to1_if.sv
// Bundle of mux data/select inputs and result/error outputs (err_cnt only with DEGENERATE_MUX_ERR_CNT_EN).
// Wires only; no latency.
// No flow control.
interface degenerate_mux_3to1_if #(
    parameter int WIDTH = 32
);
    import degenerate_mux_pkg::*;

    logic [WIDTH-1:0] in0;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [1:0]       sel;
    logic             clr_err;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] out_q;
    logic             sel_err;
    logic             err_sticky;
`ifdef DEGENERATE_MUX_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt;

    modport master (
        output in0, in1, in2, sel, clr_err,
        input  out, out_q, sel_err, err_sticky, err_cnt
    );
    modport slave (
        input  in0, in1, in2, sel, clr_err,
        output out, out_q, sel_err, err_sticky, err_cnt
    );
`else
    modport master (
        output in0, in1, in2, sel, clr_err,
        input  out, out_q, sel_err, err_sticky
    );
    modport slave (
        input  in0, in1, in2, sel, clr_err,
        output out, out_q, sel_err, err_sticky
    );
`endif

endinterface

// File: rtl/degenerate_mux_err_mon.sv
// Invalid-select monitor: sticky flag plus saturating counter (counter only with DEGENERATE_MUX_ERR_CNT_EN).
// One-cycle latency from sel_err to err_sticky/err_cnt.
// No backpressure; samples every clk edge.
module degenerate_mux_err_mon
    import degenerate_mux_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sel_err,
    input  logic                 clr_err,
`ifdef DEGENERATE_MUX_ERR_CNT_EN
    output logic [ERR_CNT_W-1:0] err_cnt,
`endif
    output logic                 err_sticky
);

    // Clear is applied before set so an invalid select on the clearing edge is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky <= 1'b0;
        end else begin
            err_sticky <= (err_sticky & ~clr_err) | sel_err;
        end
    end

`ifdef DEGENERATE_MUX_ERR_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (clr_err) begin
            err_cnt <= sel_err ? ERR_CNT_W'(1) : '0;
        end else if (sel_err && (err_cnt != ERR_CNT_MAX)) begin
            err_cnt <= err_cnt + ERR_CNT_W'(1);
        end
    end
`endif

endmodule

// File: rtl/degenerate_mux_3to1.sv
// 3:1 word mux with degenerate code 2'b11 -> zero, registered copy and error monitor (DEGENERATE_MUX_ERR_CNT_EN adds err_cnt).
// out/sel_err zero latency; out_q/err_sticky/err_cnt one cycle.
// No backpressure; accepts new inputs every cycle.
module degenerate_mux_3to1
    import degenerate_mux_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    degenerate_mux_3to1_if.slave bus
);

    logic [WIDTH-1:0] mux_dat;
    logic             sel_err;

    // Unknown select codes fall into the default branch and yield zero.
    always_comb begin
        mux_dat = '0;
        case (bus.sel)
            SEL_IN0: mux_dat = bus.in0;
            SEL_IN1: mux_dat = bus.in1;
            SEL_IN2: mux_dat = bus.in2;
            SEL_INV: mux_dat = '0;
            default: mux_dat = '0;
        endcase
    end

    assign sel_err     = (bus.sel == SEL_INV);
    assign bus.out     = mux_dat;
    assign bus.sel_err = sel_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_q <= '0;
        end else begin
            bus.out_q <= mux_dat;
        end
    end

    degenerate_mux_err_mon u_err_mon (
        .clk        (clk),
        .rst_n      (rst_n),
        .sel_err    (sel_err),
        .clr_err    (bus.clr_err),
`ifdef DEGENERATE_MUX_ERR_CNT_EN
        .err_cnt    (bus.err_cnt),
`endif
        .err_sticky (bus.err_sticky)
    );

endmodule

// File: tb/tb_degenerate_mux_3to1.sv
// Randomized and directed bench for degenerate_mux_3to1 against a behavioural model.
// Covers err_cnt only when DEGENERATE_MUX_ERR_CNT_EN is defined.
module tb_degenerate_mux_3to1;

    localparam int WIDTH = 32;

    logic clk    = 1'b0;
    logic clk_en = 1'b0;
    logic rst_n  = 1'b0;

    degenerate_mux_3to1_if #(.WIDTH(WIDTH)) bus ();

    degenerate_mux_3to1 #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state
    logic [WIDTH-1:0] exp_q;
    bit               exp_sticky;
    int               exp_cnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] ref_out();
        logic [WIDTH-1:0] words [3];
        int s;
        words[0] = bus.in0;
        words[1] = bus.in1;
        words[2] = bus.in2;
        s = int'(bus.sel);
        return (s < 3) ? words[s] : '0;
    endfunction

    task automatic check_regs(input string tag);
        check({tag, ".out_q"}, 64'(bus.out_q), 64'(exp_q));
        check({tag, ".err_sticky"}, 64'(bus.err_sticky), 64'(exp_sticky));
`ifdef DEGENERATE_MUX_ERR_CNT_EN
        check({tag, ".err_cnt"}, 64'(bus.err_cnt), 64'(exp_cnt));
`endif
    endtask

    task automatic check_comb(input string tag);
        #1;
        check({tag, ".out"}, 64'(bus.out), 64'(ref_out()));
        check({tag, ".sel_err"}, 64'(bus.sel_err), 64'(bus.sel == 2'd3));
    endtask

    // One clock edge: advance the model using the values held across the edge, then check.
    task automatic tick(input string tag);
        bit inv;
        @(posedge clk);
        inv = (bus.sel == 2'd3);
        if (rst_n) begin
            exp_q      = ref_out();
            exp_sticky = (exp_sticky && !bus.clr_err) || inv;
            if (bus.clr_err)  exp_cnt = inv ? 1 : 0;
            else if (inv)     exp_cnt = (exp_cnt >= 255) ? 255 : exp_cnt + 1;
        end
        #1;
        check_regs(tag);
    endtask

    task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] c, input logic [1:0] s, input logic clr);
        bus.in0     = a;
        bus.in1     = b;
        bus.in2     = c;
        bus.sel     = s;
        bus.clr_err = clr;
    endtask

    task automatic async_reset_pulse();
        #2;
        rst_n      = 1'b0;
        exp_q      = '0;
        exp_sticky = 1'b0;
        exp_cnt    = 0;
        #1;
        check_regs("arst");
        drive($urandom, $urandom, $urandom, 2'($urandom_range(0, 3)), 1'b0);
        check_comb("arst_track");
        tick("arst_hold");
        rst_n = 1'b1;
    endtask

    initial begin
        exp_q      = '0;
        exp_sticky = 1'b0;
        exp_cnt    = 0;

        // Combinational path with the clock stopped and reset held
        drive(32'h12153524, 32'hC0895E81, 32'h8484D609, 2'd0, 1'b0);
        #1;
        check_regs("rst");
        check("sel0.out", 64'(bus.out), 64'h12153524);
        bus.sel = 2'd1;
        #1 check("sel1.out", 64'(bus.out), 64'hC0895E81);
        bus.sel = 2'd2;
        #1 check("sel2.out", 64'(bus.out), 64'h8484D609);
        bus.sel = 2'd3;
        #1 check("sel3.out", 64'(bus.out), 64'h0);
        check("sel3.sel_err", 64'(bus.sel_err), 64'h1);
        bus.sel = 2'd0;
        #1 check("sel0.sel_err", 64'(bus.sel_err), 64'h0);

        // Clock running in reset: registers stay zero regardless of inputs
        clk_en = 1'b1;
        bus.sel = 2'd3;
        tick("rst_clk0");
        tick("rst_clk1");
        rst_n = 1'b1;

        // Registered path: sel 0 then sel 2
        drive(32'hA5A5_0001, 32'h5A5A_0002, 32'hDEAD_BEEF, 2'd0, 1'b0);
        check_comb("reg_sel0");
        tick("reg_cap0");
        check("reg_cap0.in0", 64'(bus.out_q), 64'hA5A5_0001);
        bus.sel = 2'd2;
        check_comb("reg_sel2");
        tick("reg_cap2");
        check("reg_cap2.in2", 64'(bus.out_q), 64'hDEAD_BEEF);

        // Sticky set, hold, clear, clear-with-invalid
        bus.sel = 2'd3;
        tick("stk_set");
        check("stk_set.direct", 64'(bus.err_sticky), 64'h1);
        bus.sel = 2'd0;
        tick("stk_hold");
        check("stk_hold.direct", 64'(bus.err_sticky), 64'h1);
        bus.clr_err = 1'b1;
        tick("stk_clr");
        check("stk_clr.direct", 64'(bus.err_sticky), 64'h0);
        bus.sel = 2'd3;
        tick("stk_clr_inv");
        check("stk_clr_inv.direct", 64'(bus.err_sticky), 64'h1);
        bus.clr_err = 1'b0;

        // Saturation over 300 invalid edges
        bus.sel = 2'd3;
        for (int i = 0; i < 300; i++) tick("sat");
`ifdef DEGENERATE_MUX_ERR_CNT_EN
        check("sat.direct", 64'(bus.err_cnt), 64'hFF);
`endif
        drive(bus.in0, bus.in1, bus.in2, 2'd0, 1'b1);
        tick("cnt_clr");
`ifdef DEGENERATE_MUX_ERR_CNT_EN
        check("cnt_clr.direct", 64'(bus.err_cnt), 64'h0);
`endif
        bus.clr_err = 1'b0;

        // Randomized traffic with a mid-run asynchronous reset
        for (int i = 0; i < 400; i++) begin
            drive($urandom, $urandom, $urandom, 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 7) == 0));
            check_comb("rnd");
            tick("rnd");
            if (i == 200) async_reset_pulse();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
